regfile_sb: RTL

- Parametrised successor to the single-cycle register file, for the pipelined datapath.
- Provides NUM_RD combinational read ports with write-to-read bypass and a hardwired zero register.
- Adds a per-register pending-write scoreboard: decode claims a destination, WB releases it, and each read port reports whether its operand is still in flight.
- Sits between ID (reads/claims) and WB (writes/releases).

---
 rtl/regfile_sb_pkg.sv | 23 ++
 rtl/regfile_sb_counter.sv | 39 +++
 rtl/regfile_sb.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// ============================================================================
// Module : regfile_sb_pkg
// Brief  : Shared constants and helpers for the scoreboarded register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_sb_pkg;

  localparam int REG_ZERO       = 0;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NUM_RD = 2;
  localparam int DEFAULT_CNT_W  = 2;

  // Low bit of element idx inside a packed bus of width-bit elements.
  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb_counter.sv
// ============================================================================
// Module : sb_counter
// Brief  : Saturating up/down pending-writer counter for one register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             claim,
  input  logic             rel,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             atMax
);

  logic [CNT_W-1:0] r_cnt;

  assign count   = r_cnt;
  assign nonzero = (r_cnt != '0);
  assign atMax   = (r_cnt == {CNT_W{1'b1}});

  // Claim and release together cancel; guards keep the count in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (claim && !rel && !atMax) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (rel && !claim && nonzero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module : regfile_sb
// Brief  : Multi-port register file with WB bypass and pending-write scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ok
);

  localparam int              DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [CNT_W-1:0]  w_cnt     [DEPTH];
  logic [DEPTH-1:0]  w_nonzero;
  logic [DEPTH-1:0]  w_atMax;
  logic [DEPTH-1:0]  w_rel;
  logic [DEPTH-1:0]  w_pendReg;
  logic              w_claimOk;

  // A full register may still take a claim when WB frees a slot this cycle.
  assign w_claimOk = claim_en && (claim_addr != c_zero) &&
                     (!w_atMax[claim_addr] || w_rel[claim_addr]);
  assign claim_ok  = w_claimOk;

  // Register 0 has no counter: never pending, never full, never released.
  assign w_cnt[0]     = '0;
  assign w_nonzero[0] = 1'b0;
  assign w_atMax[0]   = 1'b0;
  assign w_rel[0]     = 1'b0;
  assign w_pendReg[0] = 1'b0;

  generate
    for (genvar r = 1; r < DEPTH; r++) begin : g_reg
      localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(r);

      logic w_claimHere;

      assign w_claimHere = w_claimOk && (claim_addr == c_idx);
      assign w_rel[r]    = wr_en && (wr_addr == c_idx) && w_nonzero[r];

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .claim   (w_claimHere),
        .rel     (w_rel[r]),
        .count   (w_cnt[r]),
        .nonzero (w_nonzero[r]),
        .atMax   (w_atMax[r])
      );

      // Pending as seen after this cycle's WB release, so bypassed data is clean.
      assign w_pendReg[r] = ((w_cnt[r] - CNT_W'(w_rel[r])) != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != c_zero)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int c_aLo = sliceLo(k, ADDR_W);
      localparam int c_dLo = sliceLo(k, DATA_W);

      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rdata;

      assign w_ra = rd_addr[c_aLo +: ADDR_W];

      always_comb begin
        w_rdata = '0;
        if (w_ra == c_zero) begin
          w_rdata = '0;
        end else if (wr_en && (wr_addr == w_ra)) begin
          w_rdata = wr_data;
        end else begin
          w_rdata = r_mem[w_ra];
        end
      end

      assign rd_data[c_dLo +: DATA_W] = w_rdata;
      assign rd_pend[k]               = w_pendReg[w_ra];
    end
  endgenerate

endmodule

`default_nettype wire
